sram_mac_sequencer: RTL and testbench

Sequences a dot-product over two operand SRAMs and presents the accumulated result on a valid/ready port. It drives a shared address and enable to two synchronous-read operand SRAMs (1-cycle registered read, 16 words), multiply-accumulates the returned words, and holds the result until the consumer (the result FIFO) accepts it. It sits between the top-level control and the SRAM/FIFO datapath of the MAC block.

---
 rtl/mac_seq_pkg.sv | 15 +
 rtl/sram_mac_sequencer_if.sv | 31 +++
 rtl/mac_seq_acc.sv | 31 +++
 rtl/sram_mac_sequencer.sv | 100 ++++++++++
 tb/tb_sram_mac_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the SRAM dot-product sequencer.
package mac_seq_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 4;
   localparam int ACC_WIDTH  = 2 * DATA_WIDTH + ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/sram_mac_sequencer_if.sv
// Operand SRAM read bus plus the result valid/ready port of the sequencer.
interface sram_mac_sequencer_if
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = mac_seq_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = mac_seq_pkg::ADDR_WIDTH,
   parameter int ACC_WIDTH  = mac_seq_pkg::ACC_WIDTH
) ();

   logic [ADDR_WIDTH-1:0] sram_addr;
   logic                  sram_en;
   logic [DATA_WIDTH-1:0] sram_a_dout;
   logic [DATA_WIDTH-1:0] sram_b_dout;
   logic [ACC_WIDTH-1:0]  result;
   logic                  result_valid;
   logic                  result_ready;

   // Handshake: a transfer happens on a rising edge where result_valid and
   // result_ready are both high; once raised, result_valid stays high and
   // result stays stable until that transfer, and valid never waits on ready.
   modport master (
      output sram_addr, sram_en, result, result_valid,
      input  sram_a_dout, sram_b_dout, result_ready
   );

   modport slave (
      input  sram_addr, sram_en, result, result_valid,
      output sram_a_dout, sram_b_dout, result_ready
   );

endinterface

// File: rtl/mac_seq_acc.sv
// Unsigned multiply-accumulate register; wraps modulo 2^ACC_WIDTH.
module mac_seq_acc
   import mac_seq_pkg::*;
#(
   parameter int DATA_WIDTH = mac_seq_pkg::DATA_WIDTH,
   parameter int ACC_WIDTH  = mac_seq_pkg::ACC_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + ACC_WIDTH'(prod);
      end
   end

endmodule

// File: rtl/sram_mac_sequencer.sv
// Walks both operand SRAMs over [base, base+len), accumulates the products and
// holds the dot-product on a valid/ready port until it is accepted.
module sram_mac_sequencer
#(
   parameter int DATA_WIDTH = mac_seq_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = mac_seq_pkg::ADDR_WIDTH,
   parameter int ACC_WIDTH  = mac_seq_pkg::ACC_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [ADDR_WIDTH:0]     len,
   output logic                    busy,
   output mac_seq_pkg::state_t     dbg_state,
   sram_mac_sequencer_if.master    bus
);

   import mac_seq_pkg::*;

   localparam int CW = ADDR_WIDTH + 1;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        remaining;
   logic                 rd_valid;
   logic                 acc_clr;
   logic [ACC_WIDTH-1:0] acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (len == '0) ? HOLD : READ;
         READ:    if (remaining == CW'(1)) state_nxt = DRAIN;
         DRAIN:   state_nxt = HOLD;
         HOLD:    if (bus.result_valid && bus.result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign acc_clr = (state == IDLE) && start;

   // sram_en/result_valid are registered from the next state so they line
   // up with the state they belong to; rd_valid marks the SRAM data cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.sram_en      <= 1'b0;
         bus.sram_addr    <= '0;
         bus.result_valid <= 1'b0;
         remaining        <= '0;
         rd_valid         <= 1'b0;
      end else begin
         bus.sram_en      <= (state_nxt == READ);
         bus.result_valid <= (state_nxt == HOLD);
         rd_valid         <= bus.sram_en;
         case (state)
            IDLE: begin
               if (start) begin
                  bus.sram_addr <= base_addr;
                  remaining     <= len;
               end
            end
            READ: begin
               if (remaining != CW'(1)) begin
                  bus.sram_addr <= bus.sram_addr + ADDR_WIDTH'(1);
                  remaining     <= remaining - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   mac_seq_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_acc (
      .clk (clk),
      .rst (rst),
      .clr (acc_clr),
      .en  (rd_valid),
      .a   (bus.sram_a_dout),
      .b   (bus.sram_b_dout),
      .acc (acc)
   );

   // The accumulator is itself a register and is frozen in HOLD.
   assign bus.result = acc;
   assign busy       = (state != IDLE);
   assign dbg_state  = state;

endmodule

// File: tb/tb_sram_mac_sequencer.sv
// Self-checking bench for sram_mac_sequencer with behavioural operand SRAMs.
module tb_sram_mac_sequencer;
   import mac_seq_pkg::*;

   localparam int DW   = DATA_WIDTH;
   localparam int AW   = ADDR_WIDTH;
   localparam int ACCW = ACC_WIDTH;

   typedef struct {
      logic [AW-1:0]   base;
      logic [AW:0]     len;
      int              sel;
      logic [ACCW-1:0] exp_res;
      int              exp_lat;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy;
   state_t        dbg_state;

   sram_mac_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bus ();

   sram_mac_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [DW-1:0]   mem_a [16];
   logic [DW-1:0]   mem_b [16];
   logic [DW-1:0]   rnd_a [16];
   logic [DW-1:0]   rnd_b [16];
   logic [ACCW-1:0] exp_q [$];
   logic [AW-1:0]   addr_q [$];
   int              n_cmp = 0;
   int              n_bad = 0;
   vec_t            vecs [8];

   // Synchronous-read operand SRAMs
   always @(posedge clk) begin
      if (bus.sram_en) begin
         bus.sram_a_dout <= mem_a[bus.sram_addr];
         bus.sram_b_dout <= mem_b[bus.sram_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Address monitor: every enabled cycle must match the next expected address
   always @(negedge clk) begin
      if (!rst && bus.sram_en) begin
         if (addr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_sram_en: got addr %0d expected no read", bus.sram_addr);
         end else begin
            check("sram_addr", 32'(bus.sram_addr), 32'(addr_q.pop_front()));
         end
      end
   end

   task automatic load_mem(input int sel);
      for (int i = 0; i < 16; i++) begin
         case (sel)
            0:       begin mem_a[i] = '0;       mem_b[i] = '0;       end
            1:       begin mem_a[i] = 8'd255;   mem_b[i] = 8'd255;   end
            default: begin mem_a[i] = rnd_a[i]; mem_b[i] = rnd_b[i]; end
         endcase
      end
      if (sel == 0) begin
         mem_a[0] = 8'd1; mem_a[1] = 8'd6; mem_a[2] = 8'd5;
         mem_b[0] = 8'd2; mem_b[1] = 8'd3; mem_b[2] = 8'd4;
      end
   endtask

   function automatic logic [ACCW-1:0] dot_rnd(input logic [AW-1:0] b, input logic [AW:0] l);
      logic [ACCW-1:0] s;
      logic [AW-1:0]   a;
      s = '0;
      for (int k = 0; k < int'(l); k++) begin
         a = b + AW'(k);
         s = s + ACCW'(rnd_a[a]) * ACCW'(rnd_b[a]);
      end
      return s;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sram_en"},      32'(bus.sram_en),      0);
      check({tag, "_sram_addr"},    32'(bus.sram_addr),    0);
      check({tag, "_result"},       32'(bus.result),       0);
      check({tag, "_result_valid"}, 32'(bus.result_valid), 0);
      check({tag, "_busy"},         32'(busy),             0);
   endtask

   // One dot-product: drive start, wait for result_valid, optionally stall in
   // HOLD with start pulses, then hand the result off.
   task automatic run_op(input logic [AW-1:0] b, input logic [AW:0] l,
                         input logic [ACCW-1:0] exp_res, input int exp_lat, input int hold);
      int              lat;
      bit              got;
      logic [ACCW-1:0] exp_v;
      for (int k = 0; k < int'(l); k++) addr_q.push_back(b + AW'(k));
      exp_q.push_back(exp_res);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = l;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (c == 0) check("busy_cycle1", 32'(busy), 1);
         if (bus.result_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL result_valid_timeout: got no valid expected valid after %0d cycles", exp_lat);
         exp_q.delete();
         addr_q.delete();
         return;
      end
      exp_v = exp_q.pop_front();
      check("latency", 32'(lat), 32'(exp_lat));
      check("result", 32'(bus.result), 32'(exp_v));
      check("reads_left", 32'(addr_q.size()), 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         start = (i % 2 == 0);
         @(negedge clk);
         check("hold_valid", 32'(bus.result_valid), 1);
         check("hold_result", 32'(bus.result), 32'(exp_v));
         check("hold_state", 32'(dbg_state), 32'(HOLD));
      end
      bus.result_ready = 1'b1;
      start = (hold > 0);
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_hs_busy", 32'(busy), 0);
      check("post_hs_valid", 32'(bus.result_valid), 0);
      check("post_hs_sram_en", 32'(bus.sram_en), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      len = '0;
      bus.result_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rnd_a[i] = DW'($urandom_range(0, 255));
         rnd_b[i] = DW'($urandom_range(0, 255));
      end
      load_mem(0);

      vecs[0] = '{base: 4'd0,  len: 5'd3,  sel: 0, exp_res: 20'd40,      exp_lat: 5};
      vecs[1] = '{base: 4'd0,  len: 5'd0,  sel: 0, exp_res: 20'd0,       exp_lat: 1};
      vecs[2] = '{base: 4'd14, len: 5'd16, sel: 1, exp_res: 20'd1040400, exp_lat: 18};
      vecs[3] = '{base: 4'd1,  len: 5'd2,  sel: 0, exp_res: 20'd38,      exp_lat: 4};
      vecs[4] = '{base: 4'd1,  len: 5'd1,  sel: 0, exp_res: 20'd18,      exp_lat: 3};
      vecs[5] = '{base: 4'd14, len: 5'd4,  sel: 2, exp_res: dot_rnd(4'd14, 5'd4),  exp_lat: 6};
      vecs[6] = '{base: 4'd5,  len: 5'd16, sel: 2, exp_res: dot_rnd(4'd5, 5'd16),  exp_lat: 18};
      vecs[7] = '{base: 4'd0,  len: 5'd7,  sel: 2, exp_res: dot_rnd(4'd0, 5'd7),   exp_lat: 9};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         load_mem(vecs[v].sel);
         run_op(vecs[v].base, vecs[v].len, vecs[v].exp_res, vecs[v].exp_lat, 0);
      end

      // Stall in HOLD with start pulses, then an immediate new run
      load_mem(0);
      run_op(4'd0, 5'd3, 20'd40, 5, 10);
      run_op(4'd1, 5'd2, 20'd38, 4, 0);

      // Reset in the middle of a run
      addr_q.push_back(4'd0);
      @(posedge clk); #1;
      start = 1'b1; base_addr = 4'd0; len = 5'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrun_reset");
      addr_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("after_reset_valid", 32'(bus.result_valid), 0);
         check("after_reset_busy", 32'(busy), 0);
      end
      run_op(4'd0, 5'd3, 20'd40, 5, 0);

      // Random operations over the random memory image
      load_mem(2);
      for (int r = 0; r < 4; r++) begin
         logic [AW-1:0] rb;
         logic [AW:0]   rl;
         rb = AW'($urandom_range(0, 15));
         rl = (AW + 1)'($urandom_range(0, 16));
         run_op(rb, rl, dot_rnd(rb, rl), (rl == '0) ? 1 : int'(rl) + 2, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
